// File: rtl/viterbi_pkg.sv
// Shared constants and controller state encoding for the rate-1/2, K=7 Viterbi decoder.
package viterbi_pkg;

  localparam int K          = 7;
  localparam int NUM_STATES = 64;
  localparam int TAIL_LEN   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_TB,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/viterbi_norm_sched.sv
// Sticky normalisation request, released on the next ACS strobe that did not coincide with it.
module viterbi_norm_sched (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic norm_req,
  input  logic acs_en,
  output logic norm_en
);

  logic pending_reg;

  assign norm_en = acs_en & pending_reg;

  // A request seen during an ACS strobe is kept for the following step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end else if (enable) begin
      pending_reg <= acs_en ? norm_req : (pending_reg | norm_req);
    end
  end

endmodule

// File: rtl/viterbi_step_ctrl.sv
// Frame sequencer: symbol intake, ACS/survivor strobes per trellis step, then a full traceback sweep.
module viterbi_step_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair,
  output logic [1:0]        bm_rx_pair,
  output logic              acs_init,
  output logic              acs_en,
  input  logic              norm_req,
  output logic              norm_en,
  output logic              sm_we,
  output logic [ADDR_W-1:0] sm_waddr,
  output logic              tb_en,
  output logic              tb_first,
  output logic [ADDR_W-1:0] sm_raddr,
  output logic              busy,
  output logic              frame_done
);

  // One extra counter bit so a full 2**ADDR_W frame never wraps.
  localparam logic [ADDR_W:0]   FRAME_LEN_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(FRAME_LEN - 1);

  ctrl_state_e       state_reg, state_next;
  logic [ADDR_W:0]   step_cnt_reg;
  logic              acs_en_reg;
  logic [ADDR_W-1:0] sm_waddr_reg;
  logic [ADDR_W-1:0] sm_raddr_reg;
  logic [1:0]        bm_rx_pair_reg;
  logic              accept;
  logic              last_issue;

  assign accept     = in_valid & in_ready;
  assign last_issue = (state_reg == ST_RUN) && acs_en_reg && (sm_waddr_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    acs_init   = 1'b0;
    tb_en      = 1'b0;
    tb_first   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_next = ST_INIT;
      end
      ST_INIT: begin
        acs_init   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = (step_cnt_reg < FRAME_LEN_C);
        if (last_issue) state_next = ST_TB;
      end
      ST_TB: begin
        tb_en    = 1'b1;
        tb_first = (sm_raddr_reg == LAST_IDX);
        if (sm_raddr_reg == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accepted pair and its step index are registered; strobes fire the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_reg   <= '0;
      acs_en_reg     <= 1'b0;
      sm_waddr_reg   <= '0;
      sm_raddr_reg   <= '0;
      bm_rx_pair_reg <= '0;
    end else begin
      acs_en_reg <= 1'b0;
      case (state_reg)
        ST_INIT: step_cnt_reg <= '0;
        ST_RUN: begin
          if (accept) begin
            bm_rx_pair_reg <= rx_pair;
            acs_en_reg     <= 1'b1;
            sm_waddr_reg   <= step_cnt_reg[ADDR_W-1:0];
            step_cnt_reg   <= step_cnt_reg + 1'b1;
          end
          if (last_issue) sm_raddr_reg <= LAST_IDX;
        end
        ST_TB: begin
          if (sm_raddr_reg != '0) sm_raddr_reg <= sm_raddr_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  viterbi_norm_sched u_norm_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_reg == ST_INIT),
    .enable   (state_reg == ST_RUN),
    .norm_req (norm_req),
    .acs_en   (acs_en_reg),
    .norm_en  (norm_en)
  );

  assign acs_en     = acs_en_reg;
  assign sm_we      = acs_en_reg;
  assign sm_waddr   = sm_waddr_reg;
  assign sm_raddr   = sm_raddr_reg;
  assign bm_rx_pair = bm_rx_pair_reg;

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// Bench for viterbi_step_ctrl: timestamp-based frame model for an 8-step instance, plus a full 256-step instance.
module tb_viterbi_step_ctrl;

  localparam int FL  = 8;
  localparam int AW  = 3;
  localparam int BFL = 256;
  localparam int BAW = 8;

  logic clk;
  logic rst_n;
  logic frame_start, in_valid, norm_req;
  logic [1:0] rx_pair;
  logic in_ready, acs_init, acs_en, norm_en, sm_we, tb_en, tb_first, busy, frame_done;
  logic [1:0] bm_rx_pair;
  logic [AW-1:0] sm_waddr, sm_raddr;

  logic b_frame_start, b_in_valid, b_norm_req;
  logic [1:0] b_rx_pair;
  logic b_in_ready, b_acs_init, b_acs_en, b_norm_en, b_sm_we, b_tb_en, b_tb_first, b_busy, b_frame_done;
  logic [1:0] b_bm_rx_pair;
  logic [BAW-1:0] b_sm_waddr, b_sm_raddr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  viterbi_step_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .rx_pair(rx_pair), .bm_rx_pair(bm_rx_pair), .acs_init(acs_init),
    .acs_en(acs_en), .norm_req(norm_req), .norm_en(norm_en), .sm_we(sm_we),
    .sm_waddr(sm_waddr), .tb_en(tb_en), .tb_first(tb_first), .sm_raddr(sm_raddr),
    .busy(busy), .frame_done(frame_done)
  );

  viterbi_step_ctrl #(.FRAME_LEN(BFL), .ADDR_W(BAW)) dut_big (
    .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .rx_pair(b_rx_pair), .bm_rx_pair(b_bm_rx_pair), .acs_init(b_acs_init),
    .acs_en(b_acs_en), .norm_req(b_norm_req), .norm_en(b_norm_en), .sm_we(b_sm_we),
    .sm_waddr(b_sm_waddr), .tb_en(b_tb_en), .tb_first(b_tb_first), .sm_raddr(b_sm_raddr),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: frame timeline kept as cycle stamps (INIT cycle, last ACS cycle) plus acceptance count.
  int m_init = -1;
  int m_last = -1;
  int m_nacc = 0;
  int m_acs_idx = 0;
  bit m_acs_next = 1'b0;
  bit m_pend = 1'b0;
  logic [1:0] m_bm = 2'b00;

  int acs_cyc_q[$];
  int waddr_q[$];
  int norm_q[$];
  logic [1:0] bm_q[$];
  int done_cyc = 0;
  int tbf_addr = -1;
  int init_cnt = 0;

  always @(negedge clk) begin : compare
    bit in_init, in_run, in_tb, in_done, e_busy, e_ready, e_acs, e_norm, e_tbf;
    if (!rst_n) begin
      m_init = -1; m_last = -1; m_nacc = 0; m_bm = 2'b00; m_pend = 1'b0; m_acs_next = 1'b0;
    end else begin
      in_init = (m_init >= 0) && (cyc == m_init);
      in_run  = (m_init >= 0) && (cyc > m_init) && (m_last < 0 || cyc <= m_last);
      in_tb   = (m_last >= 0) && (cyc > m_last) && (cyc <= m_last + FL);
      in_done = (m_last >= 0) && (cyc == m_last + FL + 1);
      e_busy  = in_init | in_run | in_tb | in_done;
      e_ready = in_run && (m_nacc < FL);
      e_acs   = m_acs_next;
      e_norm  = e_acs && m_pend;
      e_tbf   = in_tb && (cyc == m_last + 1);

      chk("busy", busy, e_busy);
      chk("in_ready", in_ready, e_ready);
      chk("acs_init", acs_init, in_init);
      chk("acs_en", acs_en, e_acs);
      chk("sm_we", sm_we, e_acs);
      chk("norm_en", norm_en, e_norm);
      chk("tb_en", tb_en, in_tb);
      chk("tb_first", tb_first, e_tbf);
      chk("frame_done", frame_done, in_done);
      chk("bm_rx_pair", bm_rx_pair, m_bm);
      if (e_acs) chk("sm_waddr", sm_waddr, m_acs_idx);
      if (in_tb) chk("sm_raddr", sm_raddr, FL - 1 - (cyc - m_last - 1));

      if (acs_en) begin
        acs_cyc_q.push_back(cyc);
        waddr_q.push_back(int'(sm_waddr));
        bm_q.push_back(bm_rx_pair);
      end
      if (norm_en) norm_q.push_back(int'(sm_waddr));
      if (frame_done) done_cyc = cyc;
      if (tb_first) tbf_addr = int'(sm_raddr);
      if (acs_init) init_cnt++;

      if (in_init) m_pend = 1'b0;
      else if (in_run) m_pend = e_acs ? norm_req : (m_pend | norm_req);
      m_acs_next = 1'b0;
      if (in_valid && e_ready) begin
        m_bm = rx_pair;
        m_acs_next = 1'b1;
        m_acs_idx = m_nacc;
        m_nacc++;
        if (m_nacc == FL) m_last = cyc + 1;
      end
      if (in_done) begin
        m_init = -1;
        m_last = -1;
      end
      if (!e_busy && frame_start) begin
        m_init = cyc + 1;
        m_nacc = 0;
        m_last = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acs_cyc_q.delete(); waddr_q.delete(); norm_q.delete(); bm_q.delete();
    done_cyc = 0; tbf_addr = -1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [1:0] p);
    int g;
    g = 0;
    rx_pair  = p;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    tick();
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (!frame_done && g < 100) begin
      tick();
      g++;
    end
    chk("done_timeout", frame_done, 1'b1);
    tick();
  endtask

  logic [1:0] pairs [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

  initial begin
    int base_init, g, nacs, ntb, ninit, first_raddr;
    rst_n = 1'b0;
    frame_start = 1'b0; in_valid = 1'b0; norm_req = 1'b0; rx_pair = 2'b00;
    b_frame_start = 1'b0; b_in_valid = 1'b0; b_norm_req = 1'b0; b_rx_pair = 2'b00;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_acs_en", acs_en, 1'b0);
    chk("rst_waddr", sm_waddr, 0);
    chk("rst_raddr", sm_raddr, 0);
    chk("rst_bm", bm_rx_pair, 2'b00);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back frame
    clear_logs();
    start_frame();
    for (int i = 0; i < 8; i++) send(pairs[i]);
    wait_done();
    chk("t1_nacs", acs_cyc_q.size(), 8);
    for (int i = 0; i < acs_cyc_q.size() && i < 8; i++) begin
      chk("t1_waddr", waddr_q[i], i);
      chk("t1_bm", bm_q[i], pairs[i]);
      chk("t1_consec", acs_cyc_q[i] - acs_cyc_q[0], i);
    end
    chk("t1_tbfirst", tbf_addr, 7);
    if (acs_cyc_q.size() > 0) chk("t1_done_lat", done_cyc - acs_cyc_q[acs_cyc_q.size()-1], 9);

    // 2: in_valid toggling
    clear_logs();
    start_frame();
    tick();
    for (int i = 0; i < 8; i++) begin
      rx_pair = pairs[7-i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end
    wait_done();
    chk("t2_nacs", waddr_q.size(), 8);
    for (int i = 0; i < waddr_q.size() && i < 8; i++) chk("t2_waddr", waddr_q[i], i);
    for (int i = 0; i + 1 < acs_cyc_q.size(); i++) chk("t2_gap", acs_cyc_q[i+1] - acs_cyc_q[i], 2);

    // 3: normalisation during a bubble, then coincident with step 3's acs_en
    clear_logs();
    start_frame();
    send(pairs[0]);
    send(pairs[1]);
    in_valid = 1'b0;
    tick();
    norm_req = 1'b1;
    tick();
    norm_req = 1'b0;
    send(pairs[2]);
    send(pairs[3]);
    norm_req = 1'b1;
    send(pairs[4]);
    norm_req = 1'b0;
    for (int i = 5; i < 8; i++) send(pairs[i]);
    wait_done();
    chk("t3_nnorm", norm_q.size(), 2);
    if (norm_q.size() == 2) begin
      chk("t3_norm0", norm_q[0], 2);
      chk("t3_norm1", norm_q[1], 4);
    end

    // 4: asynchronous reset mid-run
    clear_logs();
    start_frame();
    for (int i = 0; i < 4; i++) send(pairs[i]);
    rx_pair = pairs[4];
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_acs_en", acs_en, 1'b0);
    chk("t4_sm_we", sm_we, 1'b0);
    chk("t4_in_ready", in_ready, 1'b0);
    chk("t4_waddr", sm_waddr, 0);
    chk("t4_bm", bm_rx_pair, 2'b00);
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    start_frame();
    chk("t4_reinit", acs_init, 1'b1);
    for (int i = 0; i < 8; i++) send(pairs[i]);
    wait_done();
    chk("t4_nacs", waddr_q.size(), 8);
    if (waddr_q.size() > 0) chk("t4_waddr0", waddr_q[0], 0);

    // 5: frame_start held through RUN, TB and DONE
    clear_logs();
    base_init = init_cnt;
    start_frame();
    frame_start = 1'b1;
    for (int i = 0; i < 8; i++) send(pairs[i]);
    in_valid = 1'b0;
    g = 0;
    while (!frame_done && g < 100) begin
      tick();
      g++;
    end
    chk("t5_done_seen", frame_done, 1'b1);
    tick();
    frame_start = 1'b0;
    chk("t5_idle", busy, 1'b0);
    chk("t5_ninit", init_cnt - base_init, 1);
    tick();
    chk("t5_stay_idle", busy, 1'b0);

    // 6: full 256-step frame on the wide instance
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    chk("t6_init", b_acs_init, 1'b1);
    b_rx_pair = 2'b10;
    b_in_valid = 1'b1;
    nacs = 0; ntb = 0; ninit = 0; first_raddr = -1;
    g = 0;
    while (!b_frame_done && g < 1000) begin
      tick();
      g++;
      if (b_acs_init) ninit++;
      if (b_norm_en) chk("t6_norm_en", b_norm_en, 1'b0);
      if (b_sm_we !== b_acs_en) chk("t6_we", b_sm_we, b_acs_en);
      if (!b_busy) chk("t6_busy", b_busy, 1'b1);
      if (b_acs_en) begin
        chk("t6_waddr", b_sm_waddr, nacs);
        nacs++;
      end
      if (b_tb_en) begin
        if (b_in_ready) chk("t6_ready_tb", b_in_ready, 1'b0);
        ntb++;
      end
      if (b_tb_first) first_raddr = int'(b_sm_raddr);
    end
    b_in_valid = 1'b0;
    chk("t6_done_seen", b_frame_done, 1'b1);
    chk("t6_nacs", nacs, 256);
    chk("t6_last_waddr", b_sm_waddr, 255);
    chk("t6_tb_first", first_raddr, 255);
    chk("t6_ntb", ntb, 256);
    chk("t6_ninit", ninit, 0);
    chk("t6_bm", b_bm_rx_pair, 2'b10);
    tick();
    chk("t6_idle", b_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
